// File: rtl/ddr2_fifo_rd_checker_pkg.sv
// Shared types for the DDR2 FIFO read checker: FSM state encoding and counter widths.
package ddr2_fifo_rd_checker_pkg;

    localparam int CNT_W      = 16;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_INIT = 3'd1,
        ST_RUN       = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // States in which beats are accepted and the watchdog is armed
    function automatic logic is_active(input state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/ddr2_fifo_rd_checker_if.sv
// Control, FIFO read port and status bundle of the read checker.
interface ddr2_fifo_rd_checker_if
    import ddr2_fifo_rd_checker_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              start;
    logic              phy_init_done;
    logic              empty;
    logic              dout_vd;
    logic [DATA_W-1:0] data_out;
    logic              rd_en;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [CNT_W-1:0]  words_rcvd;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output start, phy_init_done, empty, dout_vd, data_out,
        input  rd_en, busy, done, pass, timeout, words_rcvd, err_cnt
    );

    modport slave (
        input  start, phy_init_done, empty, dout_vd, data_out,
        output rd_en, busy, done, pass, timeout, words_rcvd, err_cnt
    );

endinterface

// File: rtl/ddr2_fifo_rd_checker_wdog.sv
// Inactivity watchdog: reloads to TIMEOUT-1 on i_load, counts down, flags expiry at zero.
module ddr2_fifo_rd_checker_wdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_expire
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= W'(TIMEOUT - 1);
        end else if (i_load) begin
            r_cnt <= W'(TIMEOUT - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A load in the same cycle wins, so activity on the last count never aborts
    assign o_expire = !i_load && (r_cnt == '0);

endmodule

// File: rtl/ddr2_fifo_rd_checker.sv
// Read-side checker for the DDR2-backed FIFO: drains NUM_WORDS words and compares them to SEED, SEED+1, ...
// Optional: define CHK_RESYNC_EN to re-align the expected value to the received word after a mismatch.
module ddr2_fifo_rd_checker
    import ddr2_fifo_rd_checker_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                NUM_WORDS = 150,
    parameter logic [DATA_W-1:0] SEED      = '0,
    parameter int                TIMEOUT   = 4096
) (
    input  logic                  i_rd_clk,
    input  logic                  i_reset_n,
    ddr2_fifo_rd_checker_if.slave bus
);

    localparam logic [CNT_W-1:0] NW = CNT_W'(NUM_WORDS);

    state_e            r_state;
    logic              r_init_s1, r_init_s2;
    logic [CNT_W-1:0]  r_req_cnt, r_words, r_err;
    logic [DATA_W-1:0] r_expected;
    logic              r_busy, r_done, r_pass, r_timeout;

    logic w_active, w_rd_en, w_beat, w_mismatch, w_to_drain, w_wd_load, w_expire;

    assign w_active   = is_active(r_state);
    // Reads pause while the synchronised phy_init_done is low, even mid-run
    assign w_rd_en    = (r_state == ST_RUN) && r_init_s2 && !bus.empty && (r_req_cnt < NW);
    assign w_beat     = bus.dout_vd && w_active && (r_words < NW);
    assign w_mismatch = (bus.data_out != r_expected);
    assign w_to_drain = (r_state == ST_RUN) && (r_req_cnt == NW);
    assign w_wd_load  = !w_active || bus.dout_vd || w_to_drain;

    ddr2_fifo_rd_checker_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .i_clk    (i_rd_clk),
        .i_rst_n  (i_reset_n),
        .i_load   (w_wd_load),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_rd_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_init_s1  <= 1'b0;
            r_init_s2  <= 1'b0;
            r_req_cnt  <= '0;
            r_words    <= '0;
            r_err      <= '0;
            r_expected <= SEED;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_init_s1 <= bus.phy_init_done;
            r_init_s2 <= r_init_s1;
            if (w_rd_en) r_req_cnt <= r_req_cnt + 1'b1;
            if (w_beat) begin
                r_words <= r_words + 1'b1;
                if (w_mismatch && (r_err != '1)) r_err <= r_err + 1'b1;
`ifdef CHK_RESYNC_EN
                r_expected <= w_mismatch ? bus.data_out + 1'b1 : r_expected + 1'b1;
`else
                r_expected <= r_expected + 1'b1;
`endif
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state    <= ST_WAIT_INIT;
                        r_req_cnt  <= '0;
                        r_words    <= '0;
                        r_err      <= '0;
                        r_expected <= SEED;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end
                ST_WAIT_INIT: begin
                    if (r_init_s2) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_to_drain) begin
                        r_state <= ST_DRAIN;
                    end else if (w_expire) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_words == NW) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err == '0);
                    end else if (w_expire) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_en      = w_rd_en;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.timeout    = r_timeout;
    assign bus.words_rcvd = r_words;
    assign bus.err_cnt    = r_err;

endmodule

// File: tb/tb_ddr2_fifo_rd_checker.sv
// Bench for ddr2_fifo_rd_checker: queue-based FIFO models with random latency/empty gaps and an arithmetic reference checker.
module tb_ddr2_fifo_rd_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    ddr2_fifo_rd_checker_if #(.DATA_W(32)) a_if ();
    ddr2_fifo_rd_checker_if #(.DATA_W(32)) b_if ();

    ddr2_fifo_rd_checker #(.DATA_W(32), .NUM_WORDS(150), .SEED(32'd0), .TIMEOUT(64)) u_dut_a (
        .i_rd_clk (clk),
        .i_reset_n(rst_n),
        .bus      (a_if.slave)
    );

    ddr2_fifo_rd_checker #(.DATA_W(32), .NUM_WORDS(4), .SEED(32'hFFFF_FFFE), .TIMEOUT(64)) u_dut_b (
        .i_rd_clk (clk),
        .i_reset_n(rst_n),
        .bus      (b_if.slave)
    );

    // ---------------- FIFO model for DUT A ----------------
    logic [31:0] fq[$];
    logic [31:0] sent[$];
    int  lat = 2, emode = 0, cyc = 0, rd_cnt = 0, bad_rd = 0;
    int  last_beat_cyc = 0, done_cyc = -1;
    bit  stray = 1'b0, rd_last = 1'b0;
    logic [31:0] rd_data = '0;
    bit  pv[8];
    logic [31:0] pd[8];

    initial begin
        bit fe;
        a_if.empty    = 1'b1;
        a_if.dout_vd  = 1'b0;
        a_if.data_out = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 7; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = rd_last;
            pd[0] = rd_data;
            a_if.dout_vd  = pv[lat-1];
            a_if.data_out = pv[lat-1] ? pd[lat-1] : $urandom();
            if (pv[lat-1]) last_beat_cyc = cyc;
            if (stray) begin
                a_if.dout_vd  = 1'b1;
                a_if.data_out = $urandom();
            end
            case (emode)
                1:       fe = ((cyc / 3) % 2) == 1;
                2:       fe = ($urandom_range(0, 2) == 0);
                default: fe = 1'b0;
            endcase
            a_if.empty = (fq.size() == 0) || fe;
            if (a_if.done && done_cyc < 0) done_cyc = cyc;
            #2;
            // rd_en is now settled to the value the DUT samples at the next rising edge
            rd_last = a_if.rd_en;
            rd_data = '0;
            if (rd_last) begin
                rd_cnt++;
                if (a_if.empty) bad_rd++;
                else rd_data = fq.pop_front();
            end
        end
    end

    // ---------------- FIFO model for DUT B (latency 1) ----------------
    logic [31:0] fqb[$];
    bit  b_rd = 1'b0;
    logic [31:0] b_d = '0;
    int  b_bad = 0;

    initial begin
        b_if.empty    = 1'b1;
        b_if.dout_vd  = 1'b0;
        b_if.data_out = '0;
        forever begin
            @(negedge clk);
            b_if.dout_vd  = b_rd;
            b_if.data_out = b_rd ? b_d : 32'h1234_5678;
            b_if.empty    = (fqb.size() == 0);
            #2;
            b_rd = b_if.rd_en;
            if (b_rd) begin
                if (b_if.empty) b_bad++;
                else b_d = fqb.pop_front();
            end
        end
    end

    // Reference: word i of a run must equal SEED+i; with re-sync, the word after a bad one is bad+1
    function automatic int model_err(input logic [31:0] w[$], input logic [31:0] seed, input int n);
        int errs = 0;
        logic [31:0] e;
        e = seed;
        for (int i = 0; i < n && i < w.size(); i++) begin
`ifdef CHK_RESYNC_EN
            if (w[i] !== e) begin
                errs++;
                e = w[i] + 32'd1;
            end else begin
                e = e + 32'd1;
            end
`else
            if (w[i] !== seed + 32'(i)) errs++;
`endif
        end
        if (errs > 65535) errs = 65535;
        return errs;
    endfunction

    task automatic build_seq(input int n);
        sent.delete();
        for (int i = 0; i < n; i++) sent.push_back(32'(i));
    endtask

    task automatic arm_a();
        fq     = sent;
        rd_cnt = 0;
        bad_rd = 0;
        @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        done_cyc = -1;
    endtask

    task automatic wait_done_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_if.done) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({a_if.rd_en, a_if.busy, a_if.done, a_if.pass, a_if.timeout} !== 5'b0 ||
            a_if.words_rcvd !== 16'd0 || a_if.err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_a: flags=%b words=%0d err=%0d, want all 0",
                     {a_if.rd_en, a_if.busy, a_if.done, a_if.pass, a_if.timeout}, a_if.words_rcvd, a_if.err_cnt);
        end
        n_tests++;
        if ({b_if.rd_en, b_if.busy, b_if.done, b_if.pass, b_if.timeout} !== 5'b0 ||
            b_if.words_rcvd !== 16'd0 || b_if.err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_b: flags=%b words=%0d err=%0d, want all 0",
                     {b_if.rd_en, b_if.busy, b_if.done, b_if.pass, b_if.timeout}, b_if.words_rcvd, b_if.err_cnt);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({a_if.rd_en, a_if.busy, a_if.done} !== 3'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: rd_en/busy/done=%b, want 000", {a_if.rd_en, a_if.busy, a_if.done});
        end
    endtask

    task automatic test_basic();
        bit ok;
        a_if.phy_init_done = 1'b1;
        repeat (4) @(negedge clk);
        lat = 2; emode = 0;
        build_seq(150);
        arm_a();
        wait_done_a(2000, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL basic_done: done=%b, want 1 within budget", a_if.done); end
        n_tests++;
        if (rd_cnt != 150) begin n_fail++; $display("FAIL basic_rd_en: got %0d rd_en cycles, want 150", rd_cnt); end
        n_tests++;
        if (a_if.words_rcvd !== 16'd150 || a_if.err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL basic_counts: words=%0d err=%0d, want 150/0", a_if.words_rcvd, a_if.err_cnt);
        end
        n_tests++;
        if ({a_if.pass, a_if.timeout, a_if.busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_flags: pass/timeout/busy=%b, want 100", {a_if.pass, a_if.timeout, a_if.busy});
        end
    endtask

    task automatic test_init_wait();
        bit ok;
        int viol = 0;
        a_if.phy_init_done = 1'b0;
        repeat (4) @(negedge clk);
        lat = $urandom_range(1, 4);
        build_seq(150);
        arm_a();
        repeat (500) begin
            @(negedge clk);
            if (a_if.rd_en || !a_if.busy || a_if.timeout || a_if.done) viol++;
        end
        n_tests++;
        if (viol != 0 || rd_cnt != 0) begin
            n_fail++;
            $display("FAIL init_hold: %0d bad cycles, %0d reads, want 0/0", viol, rd_cnt);
        end
        a_if.phy_init_done = 1'b1;
        wait_done_a(2000, ok);
        n_tests++;
        if (!ok || a_if.pass !== 1'b1 || a_if.words_rcvd !== 16'd150) begin
            n_fail++;
            $display("FAIL init_release: done=%b pass=%b words=%0d, want 1/1/150", a_if.done, a_if.pass, a_if.words_rcvd);
        end
    endtask

    task automatic test_inject();
        bit ok;
        int exp;
        lat = $urandom_range(1, 4);
        build_seq(150);
        sent[40] = 32'hDEAD;
        exp = model_err(sent, 32'd0, 150);
        arm_a();
        wait_done_a(2000, ok);
        n_tests++;
        if (!ok || a_if.err_cnt !== 16'(exp) || a_if.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL inject_value: done=%b err=%0d pass=%b, want 1/%0d/0", a_if.done, a_if.err_cnt, a_if.pass, exp);
        end
        build_seq(151);
        sent.delete(40);
        exp = model_err(sent, 32'd0, 150);
        arm_a();
        wait_done_a(2000, ok);
        n_tests++;
        if (!ok || a_if.err_cnt !== 16'(exp) || a_if.words_rcvd !== 16'd150) begin
            n_fail++;
            $display("FAIL inject_drop: done=%b err=%0d words=%0d, want 1/%0d/150", a_if.done, a_if.err_cnt, a_if.words_rcvd, exp);
        end
    endtask

    task automatic test_empty_toggle();
        bit ok;
        lat = 4; emode = 1;
        build_seq(150);
        arm_a();
        wait_done_a(3000, ok);
        emode = 0;
        n_tests++;
        if (bad_rd != 0) begin n_fail++; $display("FAIL toggle_rd_empty: %0d reads while empty, want 0", bad_rd); end
        n_tests++;
        if (!ok || a_if.words_rcvd !== 16'd150 || rd_cnt != 150 || a_if.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_run: done=%b words=%0d reads=%0d pass=%b, want 1/150/150/1",
                     a_if.done, a_if.words_rcvd, rd_cnt, a_if.pass);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        lat = $urandom_range(1, 4);
        build_seq(100);
        arm_a();
        wait_done_a(600, ok);
        n_tests++;
        if (!ok || a_if.timeout !== 1'b1 || a_if.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flags: done=%b timeout=%b pass=%b, want 1/1/0", a_if.done, a_if.timeout, a_if.pass);
        end
        n_tests++;
        if (a_if.words_rcvd !== 16'd100 || rd_cnt != 100) begin
            n_fail++;
            $display("FAIL timeout_words: words=%0d reads=%0d, want 100/100", a_if.words_rcvd, rd_cnt);
        end
        // A beat driven at negedge c is taken at the next rising edge; DONE follows 64 edges later
        n_tests++;
        if (done_cyc - last_beat_cyc != 1 + 64) begin
            n_fail++;
            $display("FAIL timeout_latency: done %0d cycles after last beat drive, want 65", done_cyc - last_beat_cyc);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int exp, idx;
        for (int it = 0; it < 4; it++) begin
            emode = 2;
            lat = $urandom_range(1, 6);
            build_seq(155);
            for (int j = 0; j < 3; j++) begin
                idx = $urandom_range(0, 149);
                if ($urandom_range(0, 1) == 1) sent[idx] = $urandom();
                else sent.delete(idx);
            end
            exp = model_err(sent, 32'd0, 150);
            arm_a();
            n_tests++;
            if (a_if.words_rcvd !== 16'd0 || a_if.err_cnt !== 16'd0 ||
                {a_if.timeout, a_if.done, a_if.busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL restart_clear[%0d]: words=%0d err=%0d to/done/busy=%b, want 0/0/001",
                         it, a_if.words_rcvd, a_if.err_cnt, {a_if.timeout, a_if.done, a_if.busy});
            end
            wait_done_a(4000, ok);
            n_tests++;
            if (!ok || a_if.words_rcvd !== 16'd150 || a_if.err_cnt !== 16'(exp) ||
                a_if.pass !== (exp == 0) || rd_cnt != 150 || bad_rd != 0) begin
                n_fail++;
                $display("FAIL random_run[%0d]: done=%b words=%0d err=%0d pass=%b reads=%0d bad=%0d, want 1/150/%0d/%0d/150/0",
                         it, a_if.done, a_if.words_rcvd, a_if.err_cnt, a_if.pass, rd_cnt, bad_rd, exp, exp == 0);
            end
        end
        emode = 0;
    endtask

    task automatic test_stray();
        logic [15:0] w0, e0;
        w0 = a_if.words_rcvd;
        e0 = a_if.err_cnt;
        stray = 1'b1;
        repeat (8) @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (a_if.words_rcvd !== w0 || a_if.err_cnt !== e0 || a_if.done !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_beats: words=%0d err=%0d done=%b, want %0d/%0d/1", a_if.words_rcvd, a_if.err_cnt, a_if.done, w0, e0);
        end
    endtask

    task automatic test_wrap();
        bit ok = 1'b0;
        b_if.phy_init_done = 1'b1;
        repeat (4) @(negedge clk);
        fqb = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        b_bad = 0;
        @(negedge clk) b_if.start = 1'b1;
        @(negedge clk) b_if.start = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = b_if.done;
        end
        n_tests++;
        if (!ok || b_if.words_rcvd !== 16'd4 || b_if.err_cnt !== 16'd0 || b_if.pass !== 1'b1 || b_bad != 0) begin
            n_fail++;
            $display("FAIL wrap_run: done=%b words=%0d err=%0d pass=%b bad=%0d, want 1/4/0/1/0",
                     b_if.done, b_if.words_rcvd, b_if.err_cnt, b_if.pass, b_bad);
        end
    endtask

    task automatic test_reset_midrun();
        bit ok = 1'b0;
        fqb = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        @(negedge clk) b_if.start = 1'b1;
        @(negedge clk) b_if.start = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (b_if.words_rcvd >= 16'd2) && !b_if.done;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL midrun_reach: words=%0d done=%b, want >=2 while running", b_if.words_rcvd, b_if.done); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({b_if.rd_en, b_if.busy, b_if.done, b_if.pass, b_if.timeout} !== 5'b0 ||
            b_if.words_rcvd !== 16'd0 || b_if.err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: flags=%b words=%0d err=%0d, want all 0",
                     {b_if.rd_en, b_if.busy, b_if.done, b_if.pass, b_if.timeout}, b_if.words_rcvd, b_if.err_cnt);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({b_if.rd_en, b_if.busy, b_if.done} !== 3'b0 || b_if.words_rcvd !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_idle: rd_en/busy/done=%b words=%0d, want 000/0", {b_if.rd_en, b_if.busy, b_if.done}, b_if.words_rcvd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "bench time limit");
    end

    initial begin
        a_if.start = 1'b0;
        a_if.phy_init_done = 1'b0;
        b_if.start = 1'b0;
        b_if.phy_init_done = 1'b0;
        test_reset();
        test_basic();
        test_init_wait();
        test_inject();
        test_empty_toggle();
        test_timeout();
        test_back_to_back();
        test_stray();
        test_wrap();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
